// File: rtl/pkt_field_parser_pkg.sv
// rtl/pkt_field_parser_pkg.sv - shared packet-format constants and FSM encodings for the header parser
package pkt_field_parser_pkg;

  localparam logic [2:0] PKT_HB   = 3'b000;
  localparam logic [2:0] PKT_CHE  = 3'b001;
  localparam logic [2:0] PKT_TS   = 3'b100;
  localparam logic [2:0] PKT_DATA = 3'b101;
  localparam logic [2:0] PKT_SOS  = 3'b110;

  localparam int          HDR_LEN       = 12;
  localparam logic [3:0]  HDR_LAST_IDX  = 4'(HDR_LEN - 1);
  localparam logic [15:0] NODE_BCAST_ID = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_SKIP  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_EMIT  = 3'd4
  } state_t;

endpackage

// File: rtl/pkt_field_parser_len_counter.sv
// rtl/pkt_field_parser_len_counter.sv - header byte index and payload remaining counters
module pkt_field_parser_len_counter
  import pkt_field_parser_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic       cnt_load_i,
  input  logic       cnt_inc_i,
  input  logic       rem_load_i,
  input  logic [7:0] rem_val_i,
  input  logic       rem_dec_i,
  output logic [3:0] cnt_o,
  output logic       hdr_last_o,
  output logic       rem_last_o
);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] rem_q, rem_d;

  // next-state: the FSM only increments cnt below the last header byte and only decrements rem above 1
  always_comb begin
    cnt_d = cnt_q;
    rem_d = rem_q;
    if (cnt_load_i) begin
      cnt_d = 4'd1;
    end else if (cnt_inc_i) begin
      cnt_d = cnt_q + 4'd1;
    end
    if (rem_load_i) begin
      rem_d = rem_val_i;
    end else if (rem_dec_i) begin
      rem_d = rem_q - 8'd1;
    end
  end

  // counter registers
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_q <= 4'd0;
      rem_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      rem_q <= rem_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign hdr_last_o = (cnt_q == HDR_LAST_IDX);
  assign rem_last_o = (rem_q == 8'd1);

endmodule

// File: rtl/pkt_field_parser.sv
// rtl/pkt_field_parser.sv - receive header parser with en_MNI strobe; optional DEST_FILTER_EN destination filter
module pkt_field_parser
  import pkt_field_parser_pkg::*;
#(
  parameter logic [15:0] MY_NODE_ID = 16'h000C,
  parameter logic [15:0] BCAST_ID   = NODE_BCAST_ID
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_sop,
  input  logic        in_eop,
  output logic        in_ready,
  output logic        en_MNI,
  output logic [2:0]  fPktType,
  output logic [15:0] sourceID,
  output logic [15:0] destinationID,
  output logic [15:0] hops,
  output logic [15:0] timeslot,
  output logic [15:0] e_threshold,
  output logic        pkt_err,
  output logic        busy
);

  if (MY_NODE_ID == BCAST_ID) begin : g_id_check
    $error("MY_NODE_ID must differ from BCAST_ID");
  end

  state_t      state_q, state_d;
  logic        rdy_q;
  logic        accept;
  logic        err_d, go_emit, filter_ok;
  logic        cap_byte0, cap_hdr;
  logic        cnt_load, cnt_inc, rem_load, rem_dec;
  logic [3:0]  cnt;
  logic        hdr_last, rem_last;

  logic [2:0]  sh_type_q;
  logic [15:0] sh_src_q, sh_dst_q, sh_hops_q, sh_ts_q, sh_eth_q;

  logic        en_q, err_q;
  logic [2:0]  type_q;
  logic [15:0] src_q, dst_q, hops_q, ts_q, eth_q;

  assign accept = in_valid && rdy_q;

  pkt_field_parser_len_counter u_len_counter (
    .clk        (clk),
    .nrst       (nrst),
    .cnt_load_i (cnt_load),
    .cnt_inc_i  (cnt_inc),
    .rem_load_i (rem_load),
    .rem_val_i  (in_data),
    .rem_dec_i  (rem_dec),
    .cnt_o      (cnt),
    .hdr_last_o (hdr_last),
    .rem_last_o (rem_last)
  );

`ifdef DEST_FILTER_EN
  assign filter_ok = (sh_type_q == PKT_HB) || (sh_dst_q == MY_NODE_ID) || (sh_dst_q == BCAST_ID);
`else
  assign filter_ok = 1'b1;
`endif

  // next-state and per-byte actions; a new sop always wins and restarts the header
  always_comb begin
    state_d   = state_q;
    err_d     = 1'b0;
    go_emit   = 1'b0;
    cap_byte0 = 1'b0;
    cap_hdr   = 1'b0;
    cnt_load  = 1'b0;
    cnt_inc   = 1'b0;
    rem_load  = 1'b0;
    rem_dec   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept && in_sop) begin
          if (in_eop) begin
            err_d = 1'b1;
          end else begin
            cap_byte0 = 1'b1;
            cnt_load  = 1'b1;
            state_d   = ST_HDR;
          end
        end
      end
      ST_HDR, ST_SKIP, ST_DRAIN: begin
        if (accept) begin
          if (in_sop) begin
            err_d = 1'b1;
            if (in_eop) begin
              state_d = ST_IDLE;
            end else begin
              cap_byte0 = 1'b1;
              cnt_load  = 1'b1;
              state_d   = ST_HDR;
            end
          end else if (state_q == ST_HDR) begin
            if (hdr_last) begin
              if (in_eop && in_data == 8'd0) begin
                go_emit = 1'b1;
                state_d = ST_EMIT;
              end else if (in_eop) begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end else if (in_data == 8'd0) begin
                err_d   = 1'b1;
                state_d = ST_DRAIN;
              end else begin
                rem_load = 1'b1;
                state_d  = ST_SKIP;
              end
            end else if (in_eop) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              cap_hdr = 1'b1;
              cnt_inc = 1'b1;
            end
          end else if (state_q == ST_SKIP) begin
            if (rem_last) begin
              if (in_eop) begin
                go_emit = 1'b1;
                state_d = ST_EMIT;
              end else begin
                err_d   = 1'b1;
                state_d = ST_DRAIN;
              end
            end else if (in_eop) begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end else begin
              rem_dec = 1'b1;
            end
          end else if (in_eop) begin
            state_d = ST_IDLE;
          end
        end
      end
      ST_EMIT: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state, ready and strobe registers; ready drops only for the EMIT cycle
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_q <= ST_IDLE;
      rdy_q   <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rdy_q   <= (state_d != ST_EMIT);
      en_q    <= go_emit && filter_ok;
      err_q   <= err_d;
    end
  end

  // shadow capture of header bytes 0..10, MSB first
  always_ff @(posedge clk) begin
    if (!nrst) begin
      sh_type_q <= 3'd0;
      sh_src_q  <= 16'd0;
      sh_dst_q  <= 16'd0;
      sh_hops_q <= 16'd0;
      sh_ts_q   <= 16'd0;
      sh_eth_q  <= 16'd0;
    end else if (cap_byte0) begin
      sh_type_q <= in_data[7:5];
    end else if (cap_hdr) begin
      case (cnt)
        4'd1:    sh_src_q[15:8]  <= in_data;
        4'd2:    sh_src_q[7:0]   <= in_data;
        4'd3:    sh_dst_q[15:8]  <= in_data;
        4'd4:    sh_dst_q[7:0]   <= in_data;
        4'd5:    sh_hops_q[15:8] <= in_data;
        4'd6:    sh_hops_q[7:0]  <= in_data;
        4'd7:    sh_ts_q[15:8]   <= in_data;
        4'd8:    sh_ts_q[7:0]    <= in_data;
        4'd9:    sh_eth_q[15:8]  <= in_data;
        4'd10:   sh_eth_q[7:0]   <= in_data;
        default: ;
      endcase
    end
  end

  // output fields load on entry to EMIT so they are valid alongside en_MNI, then hold
  always_ff @(posedge clk) begin
    if (!nrst) begin
      type_q <= 3'd0;
      src_q  <= 16'd0;
      dst_q  <= 16'd0;
      hops_q <= 16'd0;
      ts_q   <= 16'd0;
      eth_q  <= 16'd0;
    end else if (go_emit && filter_ok) begin
      type_q <= sh_type_q;
      src_q  <= sh_src_q;
      dst_q  <= sh_dst_q;
      hops_q <= sh_hops_q;
      ts_q   <= sh_ts_q;
      eth_q  <= sh_eth_q;
    end
  end

  assign in_ready      = rdy_q;
  assign en_MNI        = en_q;
  assign pkt_err       = err_q;
  assign busy          = (state_q != ST_IDLE);
  assign fPktType      = type_q;
  assign sourceID      = src_q;
  assign destinationID = dst_q;
  assign hops          = hops_q;
  assign timeslot      = ts_q;
  assign e_threshold   = eth_q;

endmodule

// File: tb/tb_pkt_field_parser.sv
// tb/tb_pkt_field_parser.sv - directed self-checking bench for pkt_field_parser
module tb_pkt_field_parser;

  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_sop = 1'b0;
  logic        in_eop = 1'b0;
  logic        in_ready, en_MNI, pkt_err, busy;
  logic [2:0]  fPktType;
  logic [15:0] sourceID, destinationID, hops, timeslot, e_threshold;

  int n_cmp = 0;
  int n_mis = 0;
  int en_cnt = 0;
  int err_cnt = 0;
  int en_base, err_base;
  logic [7:0] fb[$];

  always #5 clk = ~clk;

  pkt_field_parser dut (
    .clk           (clk),
    .nrst          (nrst),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_sop        (in_sop),
    .in_eop        (in_eop),
    .in_ready      (in_ready),
    .en_MNI        (en_MNI),
    .fPktType      (fPktType),
    .sourceID      (sourceID),
    .destinationID (destinationID),
    .hops          (hops),
    .timeslot      (timeslot),
    .e_threshold   (e_threshold),
    .pkt_err       (pkt_err),
    .busy          (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // strobe counters sampled on the falling edge
  always @(negedge clk) begin
    if (en_MNI) begin
      en_cnt++;
      check_eq("strobe_overlap", {31'd0, pkt_err}, 32'd0);
    end
    if (pkt_err) err_cnt++;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // called at a negedge; returns at the negedge following the accepting edge
  task automatic send_byte(input logic [7:0] d, input logic s, input logic e);
    int guard = 0;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check_eq("ready_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    in_sop   = s;
    in_eop   = e;
    @(negedge clk);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
  endtask

  task automatic build_hdr(input logic [2:0] t, input logic [15:0] src, input logic [15:0] dst,
                           input logic [15:0] hp, input logic [15:0] ts, input logic [15:0] eth,
                           input int len);
    logic [7:0] lb;
    lb = 8'(len);
    fb.delete();
    fb.push_back({t, 5'b00000});
    fb.push_back(src[15:8]); fb.push_back(src[7:0]);
    fb.push_back(dst[15:8]); fb.push_back(dst[7:0]);
    fb.push_back(hp[15:8]);  fb.push_back(hp[7:0]);
    fb.push_back(ts[15:8]);  fb.push_back(ts[7:0]);
    fb.push_back(eth[15:8]); fb.push_back(eth[7:0]);
    fb.push_back(lb);
    for (int i = 0; i < len; i++) fb.push_back(8'(i + 1));
  endtask

  task automatic send_frame(input int n, input bit eop_last, input bit gaps);
    for (int i = 0; i < n; i++) begin
      send_byte(fb[i], i == 0, eop_last && (i == n - 1));
      if (gaps && i < n - 1) idle(1);
    end
  endtask

  task automatic mark();
    en_base  = en_cnt;
    err_base = err_cnt;
  endtask

  initial begin
    // reset
    idle(3);
    check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("rst_en", {31'd0, en_MNI}, 32'd0);
    check_eq("rst_err", {31'd0, pkt_err}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_hops", {16'd0, hops}, 32'd0);
    nrst = 1'b1;
    idle(1);
    check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);

    // 1: HB, L=0
    mark();
    build_hdr(3'b000, 16'h0001, 16'hFFFF, 16'h0003, 16'h0000, 16'h0050, 0);
    send_frame(12, 1'b1, 1'b0);
    check_eq("t1_en", {31'd0, en_MNI}, 32'd1);
    check_eq("t1_type", {29'd0, fPktType}, 32'd0);
    check_eq("t1_src", {16'd0, sourceID}, 32'h0001);
    check_eq("t1_dst", {16'd0, destinationID}, 32'hFFFF);
    check_eq("t1_hops", {16'd0, hops}, 32'd3);
    check_eq("t1_eth", {16'd0, e_threshold}, 32'h0050);
    check_eq("t1_ready", {31'd0, in_ready}, 32'd0);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    idle(1);
    check_eq("t1_en_drop", {31'd0, en_MNI}, 32'd0);
    check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);
    check_eq("t1_en_cnt", 32'(en_cnt - en_base), 32'd1);
    check_eq("t1_err_cnt", 32'(err_cnt - err_base), 32'd0);

    // 2: TS to node 000C, L=3, in_valid toggled
    mark();
    build_hdr(3'b100, 16'h0002, 16'h000C, 16'h0001, 16'h0007, 16'h0010, 3);
    send_frame(15, 1'b1, 1'b1);
    check_eq("t2_en", {31'd0, en_MNI}, 32'd1);
    check_eq("t2_type", {29'd0, fPktType}, 32'd4);
    check_eq("t2_ts", {16'd0, timeslot}, 32'd7);
    check_eq("t2_dst", {16'd0, destinationID}, 32'h000C);
    idle(2);
    check_eq("t2_en_cnt", 32'(en_cnt - en_base), 32'd1);

    // 3: eop on byte 6
    mark();
    build_hdr(3'b000, 16'h0055, 16'h0066, 16'h0077, 16'h0088, 16'h0099, 0);
    send_frame(7, 1'b1, 1'b0);
    check_eq("t3_err", {31'd0, pkt_err}, 32'd1);
    check_eq("t3_en", {31'd0, en_MNI}, 32'd0);
    check_eq("t3_busy", {31'd0, busy}, 32'd0);
    check_eq("t3_hops_hold", {16'd0, hops}, 32'd1);
    check_eq("t3_src_hold", {16'd0, sourceID}, 32'h0002);
    idle(2);
    check_eq("t3_err_cnt", 32'(err_cnt - err_base), 32'd1);

    // 4: sop mid-SKIP, then a complete HB
    mark();
    build_hdr(3'b101, 16'h0003, 16'h000C, 16'h0004, 16'h0005, 16'h0006, 5);
    send_frame(14, 1'b0, 1'b0);
    check_eq("t4_skip_busy", {31'd0, busy}, 32'd1);
    build_hdr(3'b000, 16'h0001, 16'hFFFF, 16'h0009, 16'h0000, 16'h0050, 0);
    send_byte(fb[0], 1'b1, 1'b0);
    check_eq("t4_abort_err", {31'd0, pkt_err}, 32'd1);
    for (int i = 1; i < 12; i++) send_byte(fb[i], 1'b0, i == 11);
    check_eq("t4_en", {31'd0, en_MNI}, 32'd1);
    check_eq("t4_hops", {16'd0, hops}, 32'd9);
    idle(2);
    check_eq("t4_en_cnt", 32'(en_cnt - en_base), 32'd1);
    check_eq("t4_err_cnt", 32'(err_cnt - err_base), 32'd1);

    // 5: L=2 without eop on byte13, drain, then a normal packet
    mark();
    build_hdr(3'b101, 16'h0011, 16'h000C, 16'h0002, 16'h0003, 16'h0004, 2);
    send_frame(14, 1'b0, 1'b0);
    check_eq("t5_err", {31'd0, pkt_err}, 32'd1);
    check_eq("t5_drain_busy", {31'd0, busy}, 32'd1);
    send_byte(8'hAA, 1'b0, 1'b0);
    send_byte(8'hBB, 1'b0, 1'b1);
    check_eq("t5_drain_noerr", {31'd0, pkt_err}, 32'd0);
    check_eq("t5_drain_done", {31'd0, busy}, 32'd0);
    build_hdr(3'b101, 16'h0021, 16'h000C, 16'h0022, 16'h0023, 16'h1234, 1);
    send_frame(13, 1'b1, 1'b0);
    check_eq("t5_en", {31'd0, en_MNI}, 32'd1);
    check_eq("t5_eth", {16'd0, e_threshold}, 32'h1234);
    check_eq("t5_type", {29'd0, fPktType}, 32'd5);
    idle(2);
    check_eq("t5_err_cnt", 32'(err_cnt - err_base), 32'd1);

    // sop+eop on one byte, and eop on byte11 with L>0
    send_byte(8'h00, 1'b1, 1'b1);
    check_eq("sopeop_err", {31'd0, pkt_err}, 32'd1);
    check_eq("sopeop_busy", {31'd0, busy}, 32'd0);
    build_hdr(3'b000, 16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005, 4);
    send_frame(12, 1'b1, 1'b0);
    check_eq("short_err", {31'd0, pkt_err}, 32'd1);
    check_eq("short_en", {31'd0, en_MNI}, 32'd0);
    idle(1);

    // 6: CHE to 0x0005, then to 0x000C
    mark();
    build_hdr(3'b001, 16'h0007, 16'h0005, 16'h0002, 16'h0001, 16'h0003, 0);
    send_frame(12, 1'b1, 1'b0);
    check_eq("t6a_err", {31'd0, pkt_err}, 32'd0);
`ifdef DEST_FILTER_EN
    check_eq("t6a_en", {31'd0, en_MNI}, 32'd0);
    check_eq("t6a_dst_hold", {16'd0, destinationID}, 32'h000C);
`else
    check_eq("t6a_en", {31'd0, en_MNI}, 32'd1);
    check_eq("t6a_dst", {16'd0, destinationID}, 32'h0005);
`endif
    build_hdr(3'b001, 16'h0007, 16'h000C, 16'h0002, 16'h0001, 16'h0003, 0);
    send_frame(12, 1'b1, 1'b0);
    check_eq("t6b_en", {31'd0, en_MNI}, 32'd1);
    check_eq("t6b_dst", {16'd0, destinationID}, 32'h000C);
    check_eq("t6b_type", {29'd0, fPktType}, 32'd1);
    idle(1);

    // reset mid-HDR
    build_hdr(3'b110, 16'h0101, 16'h0202, 16'h0303, 16'h0404, 16'h0505, 0);
    send_frame(4, 1'b0, 1'b0);
    check_eq("mid_busy", {31'd0, busy}, 32'd1);
    nrst = 1'b0;
    idle(1);
    check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
    check_eq("mid_rst_type", {29'd0, fPktType}, 32'd0);
    check_eq("mid_rst_dst", {16'd0, destinationID}, 32'd0);
    check_eq("mid_rst_hops", {16'd0, hops}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, in_ready}, 32'd0);
    check_eq("mid_rst_en", {31'd0, en_MNI}, 32'd0);
    nrst = 1'b1;
    idle(1);
    check_eq("mid_rel_ready", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
